// File: rtl/fft4_pkg.sv
// rtl/fft4_pkg.sv - shared types for the fft4 core and its frame controller
package fft4_pkg;

  localparam int DATA_W = 16;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    FILL,
    WAIT,
    DRAIN
  } frame_state_t;

  // Floor divide by 4 keeps the four-term sums inside DATA_W bits
  function automatic cplx_t prescale(input cplx_t s);
    cplx_t r;
    r.re = s.re >>> 2;
    r.im = s.im >>> 2;
    return r;
  endfunction

endpackage

// File: rtl/fft4.sv
// rtl/fft4.sv - 4-point DFT core, LAT cycles from held inputs to valid outputs
module fft4
  import fft4_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  cplx_t x0,
  input  cplx_t x1,
  input  cplx_t x2,
  input  cplx_t x3,
  output cplx_t y0,
  output cplx_t y1,
  output cplx_t y2,
  output cplx_t y3
);

  cplx_t [3:0] w_y;

  // Multiplying by -j maps (a,b) to (b,-a); sums wrap at DATA_W bits
  always_comb begin
    w_y[0].re = x0.re + x1.re + x2.re + x3.re;
    w_y[0].im = x0.im + x1.im + x2.im + x3.im;
    w_y[1].re = x0.re + x1.im - x2.re - x3.im;
    w_y[1].im = x0.im - x1.re - x2.im + x3.re;
    w_y[2].re = x0.re - x1.re + x2.re - x3.re;
    w_y[2].im = x0.im - x1.im + x2.im - x3.im;
    w_y[3].re = x0.re - x1.im - x2.re + x3.im;
    w_y[3].im = x0.im + x1.re - x2.im - x3.re;
  end

  generate
    if (LAT > 1) begin : g_pipe
      cplx_t [3:0] r_pipe [LAT-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s < LAT - 1; s++) r_pipe[s] <= '0;
        end else begin
          r_pipe[0] <= w_y;
          for (int s = 1; s < LAT - 1; s++) r_pipe[s] <= r_pipe[s-1];
        end
      end

      assign y0 = r_pipe[LAT-2][0];
      assign y1 = r_pipe[LAT-2][1];
      assign y2 = r_pipe[LAT-2][2];
      assign y3 = r_pipe[LAT-2][3];
    end else begin : g_comb
      assign y0 = w_y[0];
      assign y1 = w_y[1];
      assign y2 = w_y[2];
      assign y3 = w_y[3];
    end
  endgenerate

endmodule

// File: rtl/fft4_frame_ctrl.sv
// rtl/fft4_frame_ctrl.sv - frame sequencer around fft4; FFT4_FRAME_CTRL_PRESCALE_EN enables input >>>2
module fft4_frame_ctrl
  import fft4_pkg::*;
#(
  parameter int LAT   = 2,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_re,
  output logic signed [DATA_W-1:0] out_im,
  output logic [1:0]               out_idx,
  output logic                     out_last,
  output logic [CNT_W-1:0]         frame_cnt,
  output logic                     busy
);

  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  frame_state_t     r_state;
  logic [1:0]       r_wr_idx;
  logic [1:0]       r_rd_idx;
  logic [3:0]       r_wait_cnt;
  logic [CNT_W-1:0] r_frame_cnt;
  cplx_t [3:0]      r_slot;
  cplx_t [3:0]      r_res;
  cplx_t [3:0]      w_y;
  cplx_t            w_sample;

`ifdef FFT4_FRAME_CTRL_PRESCALE_EN
  assign w_sample = prescale('{re: in_re, im: in_im});
`else
  assign w_sample = '{re: in_re, im: in_im};
`endif

  fft4 #(.LAT(LAT)) u_fft4 (
    .clk (clk),
    .rst (~reset),
    .x0  (r_slot[0]),
    .x1  (r_slot[1]),
    .x2  (r_slot[2]),
    .x3  (r_slot[3]),
    .y0  (w_y[0]),
    .y1  (w_y[1]),
    .y2  (w_y[2]),
    .y3  (w_y[3])
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= FILL;
      r_wr_idx    <= '0;
      r_rd_idx    <= '0;
      r_wait_cnt  <= '0;
      r_frame_cnt <= '0;
      r_slot      <= '0;
      r_res       <= '0;
    end else if (flush) begin
      r_state    <= FILL;
      r_wr_idx   <= '0;
      r_rd_idx   <= '0;
      r_wait_cnt <= '0;
      r_slot     <= '0;
      r_res      <= '0;
    end else begin
      case (r_state)
        FILL: begin
          if (in_valid) begin
            r_slot[r_wr_idx] <= w_sample;
            r_wr_idx         <= r_wr_idx + 2'd1;
            if (r_wr_idx == 2'd3) begin
              r_state    <= WAIT;
              r_wait_cnt <= '0;
            end
          end
        end
        WAIT: begin
          r_wait_cnt <= r_wait_cnt + 4'd1;
          if (r_wait_cnt == LAT_M1) begin
            r_res    <= w_y;
            r_state  <= DRAIN;
            r_rd_idx <= '0;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            r_rd_idx <= r_rd_idx + 2'd1;
            if (r_rd_idx == 2'd3) begin
              r_state     <= FILL;
              r_wr_idx    <= '0;
              r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  // Gating with the reset pin holds in_ready low during reset yet high on the first cycle after
  assign in_ready  = reset && (r_state == FILL);
  assign out_valid = (r_state == DRAIN);
  assign out_re    = out_valid ? r_res[r_rd_idx].re : '0;
  assign out_im    = out_valid ? r_res[r_rd_idx].im : '0;
  assign out_idx   = r_rd_idx;
  assign out_last  = out_valid && (r_rd_idx == 2'd3);
  assign frame_cnt = r_frame_cnt;
  assign busy      = (r_state != FILL) || (r_wr_idx != 2'd0);

endmodule

// File: doc/fft4_frame_ctrl.md
# fft4_frame_ctrl

Frame controller that owns one `fft4` core and sequences it from a sample stream. It collects four complex samples through a valid/ready input, loads them into the core as one frame, and waits out the core's pipeline latency. It then streams the four results out through a valid/ready output, one bin per cycle, in natural order y0..y3. It sits between the sample source and any downstream consumer, so that nothing else drives the core's parallel ports.

## Interface
- `LAT`, default 2: core latency in cycles from the input registers holding a frame to valid `y*`; legal values are 1..15.
- `CNT_W`, default 8: width of the frame counter.
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous abort of the current frame.
- `in_valid` in 1: input sample valid.
- `in_ready` out 1: controller accepts an input sample.
- `in_re`, `in_im` in 16 each: signed Q15 input sample.
- `out_valid` out 1: output bin valid.
- `out_ready` in 1: downstream accepts the output bin.
- `out_re`, `out_im` out 16 each: signed output bin.
- `out_idx` out 2: bin index of the current output.
- `out_last` out 1: high with `out_idx`==3.
- `frame_cnt` out CNT_W: number of completed frames; wraps.
- `busy` out 1: state is not FILL, or at least one sample is buffered.

## Operation
- State machine FILL → WAIT → DRAIN → FILL.
- **FILL**
  - `in_ready`=1.
  - Each handshake (`in_valid`&&`in_ready`) writes the sample into input slot `wr_idx` and increments `wr_idx`.
  - The handshake that fills slot 3 moves the machine to WAIT with `wait_cnt`=0.
- **WAIT**
  - `in_ready`=0.
  - The core inputs are driven from the 4 input slots, which are held stable.
  - `wait_cnt` increments each cycle.
  - At the edge where `wait_cnt`==LAT-1, y0..y3 are captured into 4 output registers and the machine moves to DRAIN with `rd_idx`=0.
- **DRAIN**
  - `out_valid`=1.
  - `out_re`/`out_im` show the output register at `rd_idx`, and `out_idx`=`rd_idx`.
  - On each output handshake, `rd_idx` increments.
  - The handshake at `rd_idx`==3 returns the machine to FILL, resets `wr_idx` to 0 and increments `frame_cnt`.
  - `out_valid` stays high and the data stays stable while `out_ready`=0.
- **Arithmetic**: the block does no arithmetic itself; the core's wrap-around behaviour passes through unchanged. `frame_cnt` wraps from 2^CNT_W-1 to 0.
- **`flush`** (any state): on the next edge the machine goes to FILL, `wr_idx`/`rd_idx`/`wait_cnt` become 0, and buffered samples and results are discarded. `frame_cnt` is unchanged. `flush` has priority over a simultaneous handshake, and that handshake is dropped.
- **Reset**: reset low at any point, including mid-WAIT or mid-DRAIN, clears everything immediately.
  - State = FILL; all indices, counters and slots = 0.
- **Output values while reset is low**: `in_ready`=0, `out_valid`=0, `out_re`/`out_im`/`out_idx`=0, `out_last`=0, `frame_cnt`=0, `busy`=0.
- **After reset releases**: `in_ready`=1 from the first cycle.

## Timing
- Let E0 be the edge that accepts sample 3.
- Capture happens at edge E0+LAT.
- `out_valid` is first high in the cycle after that edge.
- Minimum frame period with no stalls: 4 (FILL) + LAT (WAIT) + 4 (DRAIN) = 8+LAT cycles, which is 10 at the default LAT.
- `in_ready` and `out_valid` are never both high.
- All outputs are registered or decoded only from state; there is no combinational path from `in_valid` or `out_ready` to any output.

## Configuration
- Macro: `FFT4_FRAME_CTRL_PRESCALE_EN`.
- **Defined**: each input component is arithmetic-shifted right by 2 (floor) before it is written to a slot. This guarantees the 4-point sums cannot overflow 16 bits.
- **Undefined**: samples are stored unchanged.

## Structure
- **Shared package `fft4_pkg`**:
  - `DATA_W`=16.
  - The `cplx_t` struct {re, im} of signed DATA_W.
  - The state enum `frame_state_t` {FILL, WAIT, DRAIN}.
- **Sub-module**: one natural sub-module, the existing `fft4` core, instantiated once. Its reset port is driven by `~reset`.

## Test plan
1. **Basic frame**, macro off: send (1,0),(2,0),(3,0),(4,0) with `out_ready`=1. Expect out = 10+0i, -2+2i, -2+0i, -2-2i; `out_last` only on idx 3; `frame_cnt`=1; first `out_valid` at E0+LAT+1.
2. **Prescale**, macro on, same stimulus: slots hold 0,0,0,1. Expect out = 1+0i, 0+1i, -1+0i, 0-1i.
3. **Backpressure**: hold `out_ready`=0 for 5 cycles at idx 1. Expect idx 1 data stable and `out_valid` high throughout, no bin lost or duplicated, and `in_ready`=0 until the idx 3 handshake.
4. **Flush**: assert `flush` after 2 samples. Expect the next 4 samples to form a clean frame with correct output and `frame_cnt` incremented exactly once.
5. **Reset mid-DRAIN**: pull `reset` low at idx 2. Expect `out_valid`=0 and `frame_cnt`=0 immediately, and a correct new frame afterwards.
6. **Counter wrap**: with CNT_W=2, run 5 frames back to back. Expect `frame_cnt` sequence 1,2,3,0,1 and period 8+LAT.
